// File: rtl/circular_buffer_var.sv
// Variable-width circular buffer. Each cycle it accepts 0..MAX_WRITE words
// and pops 0..MAX_READ words. Read data is show-ahead: dout always presents
// the head entries. The design also provides occupancy/free outputs, a
// synchronous flush and sticky overflow/underflow flags.
module circular_buffer_var #(
  parameter int DEPTH     = 60,
  parameter int BITS      = 20,
  parameter int MAX_WRITE = 4,
  parameter int MAX_READ  = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1),
  parameter int WC_W      = $clog2(MAX_WRITE + 1),
  parameter int RC_W      = $clog2(MAX_READ + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      write_en,
  input  logic [WC_W-1:0]           write_cnt,
  input  logic [MAX_WRITE*BITS-1:0] din,
  output logic                      ready,
  input  logic                      read_en,
  input  logic [RC_W-1:0]           read_cnt,
  output logic [MAX_READ*BITS-1:0]  dout,
  output logic                      valid,
  output logic [CNT_W-1:0]          count,
  output logic [CNT_W-1:0]          free,
  output logic                      err_overflow,
  output logic                      err_underflow
);

  // Pointers index mem directly. SUM_W holds ptr+offset (< 2*DEPTH) without overflow.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_EXT = SUM_W'(DEPTH);
  localparam logic [SUM_W-1:0] MAX_WRITE_EXT = SUM_W'(MAX_WRITE);
  localparam logic [SUM_W-1:0] MAX_READ_EXT = SUM_W'(MAX_READ);
  localparam logic [SUM_W-1:0] ZERO_EXT = {SUM_W{1'b0}};

  // Modulo-DEPTH pointer advance. The offset never exceeds DEPTH, so a single
  // conditional subtract is enough. It works for any DEPTH, not only powers of two.
  function automatic logic [PTR_W-1:0] mod_add(input logic [PTR_W-1:0] ptr,
                                               input logic [SUM_W-1:0] inc);
    logic [SUM_W-1:0] sum_v;
    sum_v = SUM_W'(ptr) + inc;
    if (sum_v >= DEPTH_EXT) begin
      sum_v = sum_v - DEPTH_EXT;
    end else begin
      sum_v = sum_v;
    end
    return PTR_W'(sum_v);
  endfunction

  logic [BITS-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             err_ovf_r, err_unf_r, err_ovf_nxt_s, err_unf_nxt_s;

  logic [SUM_W-1:0] wcnt_s, rcnt_s, count_ext_s, free_ext_s, count_calc_s;
  logic             ready_s, valid_s, wr_accept_s, rd_accept_s;
  logic [PTR_W-1:0] wr_addr_s [MAX_WRITE];
  logic [PTR_W-1:0] rd_addr_s [MAX_READ];
  logic [MAX_READ*BITS-1:0] dout_s;

  // Widen the counts. Acceptance uses occupancy at cycle start, so a same-cycle
  // read never frees space for a write, and a same-cycle write never supplies data for a read.
  always_comb begin
    wcnt_s      = SUM_W'(write_cnt);
    rcnt_s      = SUM_W'(read_cnt);
    count_ext_s = SUM_W'(count_r);
    free_ext_s  = DEPTH_EXT - count_ext_s;
    ready_s     = (wcnt_s != ZERO_EXT) && (wcnt_s <= MAX_WRITE_EXT) && (wcnt_s <= free_ext_s);
    valid_s     = (rcnt_s != ZERO_EXT) && (rcnt_s <= MAX_READ_EXT) && (rcnt_s <= count_ext_s);
    wr_accept_s = write_en && ready_s && !flush;
    rd_accept_s = read_en && valid_s && !flush;
  end

  // Per-lane wrapped addresses for the write lanes and the show-ahead read lanes.
  always_comb begin
    for (int i = 0; i < MAX_WRITE; i++) begin
      wr_addr_s[i] = mod_add(wr_ptr_r, SUM_W'(i));
    end
    for (int j = 0; j < MAX_READ; j++) begin
      rd_addr_s[j] = mod_add(rd_ptr_r, SUM_W'(j));
    end
  end

  // Next-state logic: flush wins over traffic and clears the sticky flags.
  always_comb begin
    wr_ptr_nxt_s  = wr_ptr_r;
    rd_ptr_nxt_s  = rd_ptr_r;
    count_nxt_s   = count_r;
    err_ovf_nxt_s = err_ovf_r;
    err_unf_nxt_s = err_unf_r;
    count_calc_s  = count_ext_s;
    if (flush) begin
      wr_ptr_nxt_s  = {PTR_W{1'b0}};
      rd_ptr_nxt_s  = {PTR_W{1'b0}};
      count_nxt_s   = {CNT_W{1'b0}};
      err_ovf_nxt_s = 1'b0;
      err_unf_nxt_s = 1'b0;
    end else begin
      if (wr_accept_s) begin
        wr_ptr_nxt_s = mod_add(wr_ptr_r, wcnt_s);
        count_calc_s = count_calc_s + wcnt_s;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (rd_accept_s) begin
        rd_ptr_nxt_s = mod_add(rd_ptr_r, rcnt_s);
        count_calc_s = count_calc_s - rcnt_s;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      count_nxt_s = CNT_W'(count_calc_s);
      if (write_en && !ready_s) begin
        err_ovf_nxt_s = 1'b1;
      end else begin
        err_ovf_nxt_s = err_ovf_r;
      end
      if (read_en && !valid_s) begin
        err_unf_nxt_s = 1'b1;
      end else begin
        err_unf_nxt_s = err_unf_r;
      end
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      wr_ptr_r  <= wr_ptr_nxt_s;
      rd_ptr_r  <= rd_ptr_nxt_s;
      count_r   <= count_nxt_s;
      err_ovf_r <= err_ovf_nxt_s;
      err_unf_r <= err_unf_nxt_s;
    end
  end

  // Storage array. It is not reset, because occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_WRITE; i++) begin
      if (wr_accept_s && (SUM_W'(i) < wcnt_s)) begin
        mem_r[wr_addr_s[i]] <= din[i*BITS +: BITS];
      end
    end
  end

  // Show-ahead read lanes. Lanes beyond the stored word count read as zero.
  always_comb begin
    dout_s = {(MAX_READ*BITS){1'b0}};
    for (int i = 0; i < MAX_READ; i++) begin
      if (SUM_W'(i) < count_ext_s) begin
        dout_s[i*BITS +: BITS] = mem_r[rd_addr_s[i]];
      end else begin
        dout_s[i*BITS +: BITS] = {BITS{1'b0}};
      end
    end
  end

  assign ready         = ready_s;
  assign valid         = valid_s;
  assign dout          = dout_s;
  assign count         = count_r;
  assign free          = CNT_W'(free_ext_s);
  assign err_overflow  = err_ovf_r;
  assign err_underflow = err_unf_r;

endmodule

// File: tb/tb_circular_buffer_var.sv
// Directed bench for circular_buffer_var (DEPTH=8, BITS=8, 4-lane in/out).
module tb_circular_buffer_var;
  localparam int DEPTH = 8;
  localparam int BITS  = 8;
  localparam int MW    = 4;
  localparam int MR    = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WC_W  = $clog2(MW + 1);
  localparam int RC_W  = $clog2(MR + 1);

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 write_en;
  logic [WC_W-1:0]      write_cnt;
  logic [MW*BITS-1:0]   din;
  logic                 ready;
  logic                 read_en;
  logic [RC_W-1:0]      read_cnt;
  logic [MR*BITS-1:0]   dout;
  logic                 valid;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     free;
  logic                 err_overflow;
  logic                 err_underflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  circular_buffer_var #(
    .DEPTH(DEPTH), .BITS(BITS), .MAX_WRITE(MW), .MAX_READ(MR)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .write_en(write_en), .write_cnt(write_cnt), .din(din), .ready(ready),
    .read_en(read_en), .read_cnt(read_cnt), .dout(dout), .valid(valid),
    .count(count), .free(free),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input int wc, input logic [31:0] d,
                       input logic re, input int rc, input logic fl);
    write_en  = we;
    write_cnt = WC_W'(wc);
    din       = d;
    read_en   = re;
    read_cnt  = RC_W'(rc);
    flush     = fl;
  endtask

  // Apply one cycle of stimulus, then return 1 time unit after the edge with inputs idle.
  task automatic step(input logic we, input int wc, input logic [31:0] d,
                      input logic re, input int rc, input logic fl);
    drive(we, wc, d, re, rc, fl);
    @(posedge clk);
    #1;
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    #2;
    // Reset state.
    read_cnt = 3'd2;
    #1;
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_free", 32'(free), 32'd8);
    check_val("rst_valid", 32'(valid), 32'd0);
    check_val("rst_ready", 32'(ready), 32'd0);
    check_val("rst_dout", dout, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1. Write three words, then check show-ahead data and valid.
    step(1'b1, 3, 32'h00332211, 1'b0, 0, 1'b0);
    check_val("t1_count", 32'(count), 32'd3);
    check_val("t1_free", 32'(free), 32'd5);
    check_val("t1_dout", dout, 32'h00332211);
    read_cnt = 3'd2;
    #1;
    check_val("t1_valid", 32'(valid), 32'd1);
    step(1'b0, 0, 32'h0, 1'b1, 3, 1'b0);
    check_val("t1_drain", 32'(count), 32'd0);

    // 2. Fill to full, pop 3, refill across the wrap, then drain.
    step(1'b1, 4, 32'h04030201, 1'b0, 0, 1'b0);
    step(1'b1, 4, 32'h08070605, 1'b0, 0, 1'b0);
    check_val("t2_full_count", 32'(count), 32'd8);
    write_cnt = 3'd1;
    #1;
    check_val("t2_full_ready", 32'(ready), 32'd0);
    step(1'b0, 0, 32'h0, 1'b1, 3, 1'b0);
    step(1'b1, 3, 32'h000B0A09, 1'b0, 0, 1'b0);
    check_val("t2_wrap_count", 32'(count), 32'd8);
    check_val("t2_wrap_dout", dout, 32'h07060504);
    step(1'b0, 0, 32'h0, 1'b1, 4, 1'b0);
    check_val("t2_drain1", dout, 32'h0B0A0908);
    step(1'b0, 0, 32'h0, 1'b1, 4, 1'b0);
    check_val("t2_drain2_count", 32'(count), 32'd0);
    check_val("t2_empty_dout", dout, 32'h0);

    // 3. count=5, read 2 with write 4: the write is rejected.
    step(1'b1, 4, 32'hA4A3A2A1, 1'b0, 0, 1'b0);
    step(1'b1, 1, 32'h000000A5, 1'b0, 0, 1'b0);
    drive(1'b1, 4, 32'hB4B3B2B1, 1'b1, 2, 1'b0);
    #1;
    check_val("t3_ready", 32'(ready), 32'd0);
    check_val("t3_valid", 32'(valid), 32'd1);
    step(1'b1, 4, 32'hB4B3B2B1, 1'b1, 2, 1'b0);
    check_val("t3_count", 32'(count), 32'd3);
    check_val("t3_ovf", 32'(err_overflow), 32'd1);
    check_val("t3_unf", 32'(err_underflow), 32'd0);
    check_val("t3_dout", dout, 32'h00A5A4A3);

    // 4. Underflow with count=1, then a legal single-word read.
    step(1'b0, 0, 32'h0, 1'b1, 2, 1'b0);
    check_val("t4_count1", 32'(count), 32'd1);
    step(1'b0, 0, 32'h0, 1'b1, 2, 1'b0);
    check_val("t4_count_hold", 32'(count), 32'd1);
    check_val("t4_unf", 32'(err_underflow), 32'd1);
    check_val("t4_dout", dout, 32'h000000A5);
    step(1'b0, 0, 32'h0, 1'b1, 1, 1'b0);
    check_val("t4_count0", 32'(count), 32'd0);
    check_val("t4_unf_sticky", 32'(err_underflow), 32'd1);

    // 5. Flush with a coincident write clears everything.
    step(1'b1, 4, 32'hC4C3C2C1, 1'b0, 0, 1'b0);
    step(1'b1, 2, 32'h0000C6C5, 1'b0, 0, 1'b0);
    check_val("t5_count6", 32'(count), 32'd6);
    check_val("t5_ovf_pre", 32'(err_overflow), 32'd1);
    step(1'b1, 2, 32'h0000D2D1, 1'b0, 0, 1'b1);
    check_val("t5_count", 32'(count), 32'd0);
    check_val("t5_free", 32'(free), 32'd8);
    check_val("t5_ovf", 32'(err_overflow), 32'd0);
    check_val("t5_unf", 32'(err_underflow), 32'd0);
    check_val("t5_dout", dout, 32'h0);

    // 6. Asynchronous reset between edges, then restart from pointer 0.
    step(1'b1, 4, 32'hE4E3E2E1, 1'b0, 0, 1'b0);
    check_val("t6_count4", 32'(count), 32'd4);
    #3;
    rst = 1'b1;
    read_cnt = 3'd1;
    #1;
    check_val("t6_rst_count", 32'(count), 32'd0);
    check_val("t6_rst_valid", 32'(valid), 32'd0);
    check_val("t6_rst_dout", dout, 32'h0);
    #1;
    rst = 1'b0;
    read_cnt = 3'd0;
    @(posedge clk);
    #1;
    step(1'b1, 2, 32'h0000F2F1, 1'b0, 0, 1'b0);
    check_val("t6_post_dout", dout, 32'h0000F2F1);
    step(1'b0, 0, 32'h0, 1'b1, 2, 1'b0);
    check_val("t6_post_count", 32'(count), 32'd0);

    // Zero-count and oversized write requests are rejected and flagged.
    write_cnt = 3'd0;
    #1;
    check_val("zero_wc_ready", 32'(ready), 32'd0);
    step(1'b1, 0, 32'h0, 1'b0, 0, 1'b0);
    check_val("zero_wc_ovf", 32'(err_overflow), 32'd1);
    check_val("zero_wc_count", 32'(count), 32'd0);
    write_cnt = 3'd5;
    #1;
    check_val("big_wc_ready", 32'(ready), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
